// File: rtl/btb_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookups read the current table state combinationally; updates from execute train it on the clock edge.
module btb_branch_predictor #(
  parameter int ADDR_WIDTH = 26,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] update_target,
  output logic [31:0]           hit_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic                  r_valid  [ENTRIES];
  logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
  logic [1:0]            r_ctr    [ENTRIES];
  logic [31:0]           r_hit_count;

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic                  w_lk_hit;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0]   w_up_tag;
  logic                  w_up_hit;
  logic [1:0]            w_ctr_next;
  logic                  w_unused_bits;

  // Byte-offset bits of both PCs carry no information for a word-aligned fetch.
  assign w_unused_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  assign w_lk_idx = lookup_pc[INDEX_BITS+1:2];
  assign w_lk_tag = lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign pred_valid  = w_lk_hit;
  assign pred_taken  = w_lk_hit & r_ctr[w_lk_idx][1];
  assign pred_target = w_lk_hit ? r_target[w_lk_idx] : '0;

  assign w_up_idx = update_pc[INDEX_BITS+1:2];
  assign w_up_tag = update_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  always_comb begin
    w_ctr_next = r_ctr[w_up_idx];
    if (update_taken) begin
      if (r_ctr[w_up_idx] != 2'b11) w_ctr_next = r_ctr[w_up_idx] + 2'd1;
    end else begin
      if (r_ctr[w_up_idx] != 2'b00) w_ctr_next = r_ctr[w_up_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
      r_hit_count <= '0;
    end else if (update_valid) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_next;
        if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
      end else if (update_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_ctr[w_up_idx]   <= 2'b10;
      end
    end
  end

  // Any taken update either allocates or retrains the entry with this tag, so the
  // tag rewrite on a hit is harmless; not-taken updates never touch tag/target.
  always_ff @(posedge clk) begin
    if (!rst && update_valid && update_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= update_target;
    end
  end

  assign hit_count = r_hit_count;

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Directed, table-driven bench for btb_branch_predictor: each row drives one cycle of
// lookup/update and checks the outputs seen before that cycle's update takes effect.
module tb_btb_branch_predictor;

  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] lookup_pc;
  logic          pred_valid;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic          update_valid;
  logic [AW-1:0] update_pc;
  logic          update_taken;
  logic [AW-1:0] update_target;
  logic [31:0]   hit_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  btb_branch_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .update_target(update_target),
    .hit_count    (hit_count)
  );

  typedef struct {
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic [AW-1:0] lk_pc;
    logic          exp_valid;
    logic          exp_taken;
    logic [AW-1:0] exp_target;
    logic [31:0]   exp_hits;
  } vec_t;

  vec_t vecs[$];

  localparam logic [AW-1:0] PA  = 26'h2000040;
  localparam logic [AW-1:0] PB  = 26'h2000140;
  localparam logic [AW-1:0] PC  = 26'h2000080;
  localparam logic [AW-1:0] T1  = 26'h2000100;
  localparam logic [AW-1:0] T2  = 26'h2000200;
  localparam logic [AW-1:0] T3  = 26'h2000300;
  localparam logic [AW-1:0] TX  = 26'h3FFFFFC;

  task automatic add(input logic uv, input logic [AW-1:0] upc, input logic ut,
                     input logic [AW-1:0] utg, input logic [AW-1:0] lpc,
                     input logic ev, input logic et, input logic [AW-1:0] etg,
                     input logic [31:0] eh);
    vec_t v;
    v.upd_valid = uv; v.upd_pc = upc; v.upd_taken = ut; v.upd_target = utg;
    v.lk_pc = lpc; v.exp_valid = ev; v.exp_taken = et; v.exp_target = etg; v.exp_hits = eh;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_lookup(input string name, input logic [AW-1:0] pc,
                              input logic ev, input logic et, input logic [AW-1:0] etg);
    lookup_pc = pc;
    #1;
    check({name, ".valid"},  {31'd0, pred_valid}, {31'd0, ev});
    check({name, ".taken"},  {31'd0, pred_taken}, {31'd0, et});
    check({name, ".target"}, {6'd0, pred_target}, {6'd0, etg});
  endtask

  initial begin
    // Rows: update fields, lookup pc, then outputs expected before this row's edge.
    add(1, PA, 1, T1, PA,   0, 0, 0,  0);  // post-reset miss; allocate A ctr=10
    add(1, PA, 1, T1, PA,   1, 1, T1, 0);  // hit -> ctr 11
    add(1, PA, 1, T1, PA,   1, 1, T1, 1);  // stays 11
    add(1, PA, 1, T1, PA,   1, 1, T1, 2);  // stays 11
    add(1, PA, 0, TX, PA,   1, 1, T1, 3);  // NT -> 10, target kept
    add(1, PA, 0, TX, PA,   1, 1, T1, 4);  // NT -> 01
    add(1, PA, 0, TX, PA,   1, 0, T1, 5);  // NT -> 00
    add(1, PA, 0, TX, PA,   1, 0, T1, 6);  // NT stays 00
    add(0, PA, 1, TX, PA,   1, 0, T1, 7);  // update_valid=0 ignored
    add(1, PB, 0, T2, PA,   1, 0, T1, 7);  // not-taken alias: no allocation
    add(1, PB, 1, T2, PA,   1, 0, T1, 7);  // taken alias replaces A
    add(0, 0,  0, 0,  PA,   0, 0, 0,  7);
    add(1, PB | 26'd3, 1, T2, PB, 1, 1, T2, 7);  // unaligned update hits B -> ctr 11
    add(0, 0,  0, 0,  PB,   1, 1, T2, 8);
    add(1, PC, 1, T3, PC,   0, 0, 0,  8);  // same-cycle read sees old state
    add(0, 0,  0, 0,  PC,   1, 1, T3, 8);

    rst = 1'b1; update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
    update_target = '0; lookup_pc = PA;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst           = 1'b0;
      update_valid  = vecs[i].upd_valid;
      update_pc     = vecs[i].upd_pc;
      update_taken  = vecs[i].upd_taken;
      update_target = vecs[i].upd_target;
      lookup_pc     = vecs[i].lk_pc;
      #1;
      check($sformatf("row%0d.valid", i),  {31'd0, pred_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("row%0d.taken", i),  {31'd0, pred_taken}, {31'd0, vecs[i].exp_taken});
      check($sformatf("row%0d.target", i), {6'd0, pred_target}, {6'd0, vecs[i].exp_target});
      check($sformatf("row%0d.hits", i),   hit_count, vecs[i].exp_hits);
      $display("row %0d: upd v=%0b pc=%h t=%0b tgt=%h | lookup %h -> v=%0b t=%0b tgt=%h hits=%0d",
               i, update_valid, update_pc, update_taken, update_target, lookup_pc,
               pred_valid, pred_taken, pred_target, hit_count);
    end

    // Reset concurrent with a taken update: reset wins and the table is emptied.
    @(negedge clk);
    rst = 1'b1; update_valid = 1'b1; update_pc = PA; update_taken = 1'b1; update_target = T1;
    @(negedge clk);
    rst = 1'b0; update_valid = 1'b0;
    check_lookup("rst.A", PA, 0, 0, 0);
    check_lookup("rst.B", PB, 0, 0, 0);
    check_lookup("rst.C", PC, 0, 0, 0);
    check("rst.hits", hit_count, 32'd0);
    $display("reset-with-update: lookups after reset valid=%0b hits=%0d", pred_valid, hit_count);

    // Table still trains normally after that reset.
    update_valid = 1'b1; update_pc = PC; update_taken = 1'b1; update_target = T2;
    @(negedge clk);
    update_valid = 1'b0;
    check_lookup("realloc.C", PC, 1, 1, T2);
    $display("realloc after reset: lookup %h -> v=%0b tgt=%h", lookup_pc, pred_valid, pred_target);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_branch_predictor.md
Name: btb_branch_predictor

Overview:
- Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.
- Sits upstream of the fetch unit and drives its branch-prediction input (valid, prediction, target) from the current fetch PC.
- Trained by the resolved-branch update port from execute.
- Lookup is a same-cycle combinational read of registered table state. All state changes happen on the rising clock edge.

Parameters:
- ADDR_WIDTH, 26, byte-address width of all PCs and targets.
- INDEX_BITS, 6, log2 of entry count (64 entries). Index = pc[INDEX_BITS+1:2].
- TAG_BITS, ADDR_WIDTH-INDEX_BITS-2, tag = pc[ADDR_WIDTH-1:INDEX_BITS+2]. Includes the thread MSB.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- lookup_pc  in  ADDR_WIDTH  current fetch PC.
- pred_valid  out  1  lookup hit: entry valid and tag match.
- pred_taken  out  1  counter[1] of hit entry; 0 on miss.
- pred_target  out  ADDR_WIDTH  stored target on hit; 0 on miss.
- update_valid  in  1  resolved branch this cycle.
- update_pc  in  ADDR_WIDTH  PC of resolved branch.
- update_taken  in  1  actual direction.
- update_target  in  ADDR_WIDTH  actual taken target.
- hit_count  out  32  number of update cycles that hit the table; saturates at 0xFFFFFFFF.

Behaviour:
- Storage per entry:
  - valid (1)
  - tag (TAG_BITS)
  - target (ADDR_WIDTH)
  - ctr (2): 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (rst=1 at edge):
  - all valid <= 0, all ctr <= 01, hit_count <= 0.
  - tag/target are don't-care.
  - Outputs in the cycle after reset: pred_valid=0, pred_taken=0, pred_target=0.
- Lookup: combinational from lookup_pc and current register state, zero latency.
  - pred_taken and pred_target are forced to 0 whenever pred_valid=0.
- Update (update_valid=1 at edge), with idx/tag taken from update_pc. Update hit = valid[idx] and tag match.
  - Hit, taken: ctr <= sat_inc(ctr) (11 stays 11); target <= update_target.
  - Hit, not taken: ctr <= sat_dec(ctr) (00 stays 00); target unchanged.
  - Miss, taken: allocate/replace. valid<=1, tag<=new tag, target<=update_target, ctr<=10.
  - Miss, not taken: no change; no allocation.
  - hit_count increments on every update hit, saturating.
- update_valid=0: no table change.
- Simultaneous lookup and update to the same index:
  - lookup returns pre-update state (read-old).
  - New state is visible from the next cycle.
- Aliasing: a different tag at the same index replaces the entry only on a taken miss. A not-taken alias leaves the resident entry intact.
- rst asserted together with update_valid: reset wins, the update is dropped.
- rst mid-operation clears every entry in one cycle; no multi-cycle clear state.
- Update PCs with bits [1:0] != 0: those bits are ignored.

Test Plan:
- Post-reset lookup:
  - Stimulus: rst 1 cycle, then lookup_pc=0x2000040.
  - Required: pred_valid=0, pred_taken=0, pred_target=0, hit_count=0.
- Allocate:
  - Stimulus: update pc=0x2000040, taken=1, target=0x2000100; next cycle lookup 0x2000040.
  - Required: pred_valid=1, pred_taken=1 (ctr=10), pred_target=0x2000100.
- Counter saturation:
  - Stimulus: after allocate, 3 taken updates; then 4 not-taken updates.
  - Required: ctr reaches 11 and stays 11. Decrements go 10, 01, 00, 00. pred_taken=0 after the second not-taken. hit_count=7.
- Alias:
  - Stimulus: entry at 0x2000040. Update pc=0x2000140 (same index, different tag), first taken=0, then taken=1 target=0x2000200.
  - Required: after the not-taken update, lookup 0x2000040 still hits. After the taken update, lookup 0x2000040 misses and lookup 0x2000140 hits with target 0x2000200, ctr=10.
- Same-cycle read/write:
  - Stimulus: lookup_pc and update_pc both 0x2000080 (empty entry), taken=1, in the same cycle.
  - Required: pred_valid=0 that cycle, pred_valid=1 the next cycle.
- Reset precedence:
  - Stimulus: populated table; rst=1 concurrent with a taken update to 0x2000040.
  - Required: every lookup misses afterwards and hit_count=0.
